uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Memory-mapped, FIFO-buffered UART transmitter. It sits on the SoC data bus beside the receive-only UART controller. The CPU stores bytes into a 16-entry FIFO, and the block serialises them onto `uart_tx` as 8N1 frames at a fixed baud rate. This gives the CPU a non-blocking console output path without stalling the pipeline.

## Interface
Parameters:
- `CLK_FREQ`, default 27000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `DIV`, default CLK_FREQ/BAUD (integer division, 234 at the defaults): clock cycles per bit; must be ≥ 2.
- `DEPTH`, default 16: FIFO entries; must be a power of two.

Ports (one clock; reset is synchronous and active-high, named `clk` and `reset`):
- `clk` in 1: system/CPU clock.
- `reset` in 1: synchronous, active-high; sampled on posedge `clk`.
- `wen` in 1: bus write strobe, qualified by `address`.
- `ren` in 1: bus read strobe, qualified by `address`.
- `address` in 4: byte offset within the block; only `address[3:2]` is decoded.
- `data_in` in 32: write data; only `[7:0]` is used.
- `data_out` out 32: registered read data.
- `uart_tx` out 1: serial output, idle high.
- `tx_busy` out 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
Register map:
- `address[3:2]=0`, TXDATA (write-only): a write pushes `data_in[7:0]`. Reads return 0.
- `address[3:2]=1`, STATUS (read-only):
  - bit0 full
  - bit1 empty
  - bit2 shifter active
  - bit3 overflow (sticky)
  - bits[8:4] FIFO count, 0..DEPTH
  - remaining bits 0
- Offsets 2 and 3: reads return 0; writes are ignored.
- `byte_select` is not used. A write to any byte lane of TXDATA pushes `data_in[7:0]`.

FIFO:
- Circular buffer with read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
- Count register of log2(DEPTH)+1 bits.
- Push while full with no pop in the same cycle: the byte is dropped, the FIFO is unchanged, and overflow is set.
- Push and pop in the same cycle: both take effect and the count is unchanged. When full, the push is accepted because the pop frees the slot.
- Overflow clears on the edge that samples a STATUS read (`ren`, offset 1). If a dropped push happens in the same cycle, set wins. The read returns the pre-clear value.

Transmit FSM, with bit counter (0..7) and baud counter (0..DIV-1):
- IDLE:
  - `uart_tx=1`.
  - If the FIFO is not empty: pop into the shift register, clear the baud counter, go to START.
- START: `uart_tx=0` for DIV cycles, then go to DATA with bit counter 0.
- DATA:
  - `uart_tx` = shift register bit0 (LSB first), held DIV cycles per bit.
  - Shift right after each bit.
  - After bit 7, go to STOP.
- STOP:
  - `uart_tx=1` for DIV cycles.
  - At the end, if the FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- `uart_tx` is driven from a flop (glitch-free).

Reset values:
- `uart_tx=1`, `tx_busy=0`, `data_out=0`.
- FIFO empty, pointers 0, count 0, overflow 0.
- FSM in IDLE, both counters 0.
- Reset mid-frame aborts the frame: the line goes high on the next edge and FIFO contents are discarded.

## Timing
- `data_out` is updated on the edge that samples `ren` and holds otherwise. Read latency is 1 cycle.
- Write accepted at edge N: count increments at N.
  - If the FSM was IDLE with the FIFO empty, the pop and the START entry happen at edge N+1.
  - `uart_tx` falls at N+1.
- Frame length: exactly 10×DIV cycles, start-bit falling edge to the end of the stop bit.
- Bit k (start = 0, data bits 1..8, stop = 9) occupies cycles [N+1+k·DIV, N+1+(k+1)·DIV).
- Back-to-back frames: the next start bit begins exactly 10×DIV cycles after the previous one.
- `tx_busy` = (state ≠ IDLE) OR (count ≠ 0). It is combinational from flops and rises in the same cycle the count becomes 1.
- STATUS reflects state as of the sampling edge. A same-cycle push is not visible in that read.

## Test plan
- Reset check: assert `reset` for 3 cycles → `uart_tx=1`, `tx_busy=0`, STATUS read returns 0x002 (empty).
- Single byte: write 0xA5 with DIV=234 → frame on `uart_tx` of start 0, then 1,0,1,0,0,1,0,1, then stop 1. Each level lasts 234 cycles, the falling edge comes 1 cycle after the write, and `tx_busy` falls 2340 cycles after the line goes low.
- Fill and overflow: with DIV=4, write 17 bytes in consecutive cycles starting at a stalled line → 16 accepted, 17th dropped, STATUS bit3=1. A second STATUS read shows bit3=0. The line emits exactly 16 frames in order.
- Back-to-back: write 0x00 then 0xFF → second start bit exactly 10×DIV cycles after the first, with no extra idle cycles.
- Simultaneous push/pop when full: with a full FIFO, write at the STOP→START pop edge → byte accepted, overflow stays 0, count stays 16.
- Reset mid-frame: assert reset during data bit 3 → `uart_tx=1` on the next edge, STATUS count 0, and no further frames are emitted.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter on a small memory-mapped register interface.
// CPU writes bytes into a circular FIFO; a registered FSM serialises them LSB first.
module uart_tx_buffered #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200,
  parameter int DIV      = CLK_FREQ / BAUD,
  parameter int DEPTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wen,
  input  logic        ren,
  input  logic [3:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [7:0]          mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                overflow;
  logic [7:0]          shift;
  logic [2:0]          bit_cnt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic                full;
  logic                empty;
  logic                baud_end;
  logic                push;
  logic                pop;
  logic                accept;
  logic                drop;
  logic                status_rd;
  logic [31:0]         status;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign push      = wen && (address[3:2] == 2'd0);
  assign status_rd = ren && (address[3:2] == 2'd1);
  // The FSM pops when idle or at the last cycle of a stop bit; a pop frees the slot for a same-cycle push.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign tx_busy   = (state != IDLE) || !empty;

  always_comb begin
    status              = '0;
    status[0]           = full;
    status[1]           = empty;
    status[2]           = (state != IDLE);
    status[3]           = overflow;
    status[4 +: CNT_W]  = count;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
      // A dropped push outranks the clear-on-read of the same cycle.
      if (drop)           overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)    data_out <= '0;
    else if (ren) data_out <= status_rd ? status : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (pop)                          shift <= mem[rd_ptr];
    else if ((state == DATA) && baud_end) shift <= shift >> 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            state    <= START;
            uart_tx  <= 1'b0;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_end) begin
            state    <= DATA;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // shift[1] becomes bit0 after this edge's shift
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus queues expected frames and reads,
// independent monitors decode the serial lines and the read data and compare.
module tb_uart_tx_buffered;

  typedef struct {
    logic [7:0] b;
    longint     t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen_a, ren_a, wen_b, ren_b;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b, dout_a, dout_b;
  logic        tx_a, tx_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] rd_q[$];

  always #5 clk = ~clk;

  uart_tx_buffered dut_a (
    .clk(clk), .reset(reset), .wen(wen_a), .ren(ren_a), .address(addr_a),
    .data_in(din_a), .data_out(dout_a), .uart_tx(tx_a), .tx_busy(busy_a)
  );

  uart_tx_buffered #(.DIV(4)) dut_b (
    .clk(clk), .reset(reset), .wen(wen_b), .ren(ren_b), .address(addr_b),
    .data_in(din_b), .data_out(dout_b), .uart_tx(tx_b), .tx_busy(busy_b)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  task automatic score(input bit sel, input logic [7:0] data, input logic bad, input longint t0);
    exp_t e;
    if (sel) begin
      if (q_b.size() == 0) begin check("unexpected_frame_b", 1, 0); return; end
      e = q_b.pop_front();
    end else begin
      if (q_a.size() == 0) begin check("unexpected_frame_a", 1, 0); return; end
      e = q_a.pop_front();
    end
    check(sel ? "frame_byte_b" : "frame_byte_a", data, e.b);
    check(sel ? "frame_shape_b" : "frame_shape_a", bad, 0);
    check(sel ? "frame_start_b" : "frame_start_a", t0, e.t);
  endtask

  // Serial monitor: samples on negedge, a frame is 10*div samples starting at the first low sample.
  task automatic frame_mon(input bit sel, input int div);
    logic [7:0] data;
    logic       lvl, bad, aborted;
    longint     t0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || line(sel) !== 1'b0) continue;
      t0 = $time - 5;
      data = '0; bad = 1'b0; aborted = 1'b0; lvl = 1'b0;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < div; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (reset !== 1'b0) aborted = 1'b1;
          if (aborted) break;
          if (c == 0) lvl = line(sel);
          else if (line(sel) !== lvl) bad = 1'b1;
          if (c == 0 && k >= 1 && k <= 8) data[k-1] = lvl;
          if (c == 0 && k == 9 && lvl !== 1'b1) bad = 1'b1;
        end
        if (aborted) break;
      end
      if (!aborted) score(sel, data, bad, t0);
    end
  endtask

  initial frame_mon(1'b0, 234);
  initial frame_mon(1'b1, 4);

  // Read monitor: data_out is checked half a cycle after the edge that sampled ren.
  initial forever begin
    @(posedge clk);
    if (ren_b === 1'b1) begin
      @(negedge clk);
      if (rd_q.size() == 0) check("unexpected_read", 1, 0);
      else check("status_read", dout_b, rd_q.pop_front());
    end
  end

  task automatic wr(input bit sel, input logic [3:0] a, input logic [7:0] b, output longint tw);
    @(negedge clk);
    if (sel) begin wen_b = 1'b1; addr_b = a; din_b = {24'hDEADBE, b}; end
    else     begin wen_a = 1'b1; addr_a = a; din_a = {24'hDEADBE, b}; end
    @(posedge clk);
    tw = $time;
    #1;
    wen_a = 1'b0;
    wen_b = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    @(negedge clk);
    ren_b = 1'b1;
    addr_b = a;
    @(posedge clk);
    #1 ren_b = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input int bound);
    int n = 0;
    while (n < bound && (sel ? busy_b : busy_a) !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    check(sel ? "drain_b" : "drain_a", sel ? busy_b : busy_a, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint tw, t0;
    wen_a = 0; ren_a = 0; addr_a = 0; din_a = 0;
    wen_b = 0; ren_b = 0; addr_b = 0; din_b = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_tx_a", tx_a, 1);
    check("reset_tx_b", tx_b, 1);
    check("reset_busy_a", busy_a, 0);
    check("reset_busy_b", busy_b, 0);
    check("reset_dout", dout_b, 0);
    rd(4'h4, 32'h002);
    rd(4'h0, 32'h0);
    rd(4'hC, 32'h0);
    wr(1'b1, 4'h8, 8'h77, tw);
    rd(4'h4, 32'h002);
    check("ignored_write_busy", busy_b, 0);

    // single byte at default divider (234)
    wr(1'b0, 4'h0, 8'hA5, tw);
    q_a.push_back('{8'hA5, tw + 10});
    #(23404);
    check("busy_before_end_a", busy_a, 1);
    #10;
    check("busy_after_end_a", busy_a, 0);

    // fill and overflow: first byte occupies the shifter, then 17 consecutive writes
    wr(1'b1, 4'h0, 8'h11, tw);
    t0 = tw;
    q_b.push_back('{8'h11, t0 + 10});
    for (int i = 0; i < 17; i++) begin
      wr(1'b1, 4'h0, 8'(32'h20 + i), tw);
      if (i < 16) q_b.push_back('{8'(32'h20 + i), t0 + 10 + 400 * (i + 1)});
    end
    rd(4'h4, 32'h10D);
    rd(4'h4, 32'h105);
    wait_idle(1'b1, 2000);

    // back-to-back frames
    wr(1'b1, 4'h0, 8'h00, tw);
    q_b.push_back('{8'h00, tw + 10});
    q_b.push_back('{8'hFF, tw + 410});
    wr(1'b1, 4'h0, 8'hFF, tw);
    wait_idle(1'b1, 400);

    // full FIFO with a push landing on the STOP->START pop edge
    wr(1'b1, 4'h0, 8'h40, tw);
    t0 = tw;
    q_b.push_back('{8'h40, t0 + 10});
    for (int i = 1; i <= 16; i++) begin
      wr(1'b1, 4'h0, 8'(32'h40 + i), tw);
      q_b.push_back('{8'(32'h40 + i), t0 + 10 + 400 * i});
    end
    rd(4'h4, 32'h105);
    #(t0 + 401 - $time);
    wr(1'b1, 4'h0, 8'h51, tw);
    q_b.push_back('{8'h51, t0 + 10 + 400 * 17});
    rd(4'h4, 32'h105);
    wait_idle(1'b1, 2000);

    // reset during data bit 3 of the first frame, with more bytes queued
    wr(1'b1, 4'h0, 8'h5A, tw);
    t0 = tw;
    wr(1'b1, 4'h0, 8'h5B, tw);
    wr(1'b1, 4'h0, 8'h5C, tw);
    #(t0 + 171 - $time);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_tx_high", tx_b, 1);
    check("abort_busy", busy_b, 0);
    rd(4'h4, 32'h002);
    repeat (300) @(negedge clk);
    check("abort_no_frames_busy", busy_b, 0);

    check("pending_frames_a", q_a.size(), 0);
    check("pending_frames_b", q_b.size(), 0);
    check("pending_reads", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
